// File: rtl/isqrt_pkg.sv
// Shared definitions for the sequential integer square root (isqrt_seq).
// Holds the controller state encoding, the default-width derived sizes and a
// helper that derives the root width from any operand width.
package isqrt_pkg;

  // Controller states: IDLE only after reset, CALC while iterating, DONE holds result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sizes for the default 8-bit operand build.
  localparam int WIDTH_DEF = 8;
  localparam int ROOT_W    = WIDTH_DEF / 2;
  localparam int REM_W     = ROOT_W + 1;
  localparam int ITER_W    = $clog2(ROOT_W);

  // Root width for an arbitrary (even) operand width.
  function automatic int root_width(input int width);
    return width / 2;
  endfunction

  // Iteration counter width; never narrower than one bit.
  function automatic int iter_width(input int rw);
    return (rw > 1) ? $clog2(rw) : 1;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One iteration of the restoring digit-by-digit square root.
// Brings down the next two operand bits, tries to subtract (4*root + 1) scaled
// as {root, 01}, and appends the resulting root bit. Purely combinational; the
// top instantiates it once and feeds it back through its registers each cycle.
module isqrt_step #(
  parameter int RW = 4
) (
  input  logic [RW:0]   rem_in,
  input  logic [RW-1:0] root_in,
  input  logic [1:0]    bits_in,
  output logic [RW:0]   rem_out,
  output logic [RW-1:0] root_out
);

  // Working width: room for {rem, 2 bits} plus a guard bit so the trial
  // subtraction can never wrap.
  localparam int TW = RW + 4;

  logic [TW-1:0] cand;
  logic [TW-1:0] sub;
  logic          take;

  assign cand = {1'b0, rem_in, bits_in};
  assign sub  = {2'b00, root_in, 2'b01};

  // Non-negative trial difference means the new root bit is 1.
  assign take = (cand >= sub);

  // Restoring step: keep the difference when it fits, otherwise keep the
  // shifted remainder. Both fit in RW+1 bits because rem never exceeds 2*root.
  always_comb begin
    rem_out  = take ? (RW+1)'(cand - sub) : (RW+1)'(cand);
    root_out = {root_in[RW-2:0], take};
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: floor(sqrt(x)) for an unsigned WIDTH-bit
// operand, one root bit per clock, with an exact-square flag.
// Handshake: start accepted in IDLE or DONE, busy during the WIDTH/2 compute
// cycles, done held with the result until the next accepted start.
// Build option: define ISQRT_REM_EN to expose the final remainder on port rem;
// without it the remainder is only used internally to derive exact.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic               exact
`ifdef ISQRT_REM_EN
  ,
  output logic [WIDTH/2:0]   rem
`endif
);

  localparam int RW     = root_width(WIDTH);
  localparam int REM_W  = RW + 1;
  localparam int ITW    = iter_width(RW);

  // Controller state
  state_t state_q, state_d;

  // Datapath registers
  logic [WIDTH-1:0] op_q, op_d;          // operand, consumed two bits per cycle from the top
  logic [REM_W-1:0] rem_p_q, rem_p_d;    // partial remainder
  logic [RW-1:0]    root_p_q, root_p_d;  // partial root
  logic [ITW-1:0]   iter_q, iter_d;      // iterations still to run after this one

  // Result registers
  logic [RW-1:0]    root_q, root_d;
  logic             exact_q, exact_d;
`ifdef ISQRT_REM_EN
  logic [REM_W-1:0] rem_q, rem_d;
`endif

  // Step outputs
  logic [REM_W-1:0] step_rem;
  logic [RW-1:0]    step_root;

  logic accept;
  logic last_iter;

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_iter = (state_q == CALC) && (iter_q == '0);

  isqrt_step #(
    .RW(RW)
  ) u_step (
    .rem_in  (rem_p_q),
    .root_in (root_p_q),
    .bits_in (op_q[WIDTH-1 -: 2]),
    .rem_out (step_rem),
    .root_out(step_root)
  );

  // State register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only honoured outside CALC; DONE holds until restarted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (iter_q == '0) state_d = DONE;
      DONE:    if (start) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on accept, iterate in CALC, publish on the last iteration.
  always_comb begin
    op_d     = op_q;
    rem_p_d  = rem_p_q;
    root_p_d = root_p_q;
    iter_d   = iter_q;
    root_d   = root_q;
    exact_d  = exact_q;
`ifdef ISQRT_REM_EN
    rem_d    = rem_q;
`endif
    if (accept) begin
      op_d     = x;
      rem_p_d  = '0;
      root_p_d = '0;
      iter_d   = ITW'(RW - 1);
    end else if (state_q == CALC) begin
      op_d     = {op_q[WIDTH-3:0], 2'b00};
      rem_p_d  = step_rem;
      root_p_d = step_root;
      iter_d   = iter_q - ITW'(1);
      if (last_iter) begin
        root_d  = step_root;
        exact_d = (step_rem == '0);
`ifdef ISQRT_REM_EN
        rem_d   = step_rem;
`endif
      end
    end
  end

  // Datapath and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rem_p_q  <= '0;
      root_p_q <= '0;
      iter_q   <= '0;
      root_q   <= '0;
      exact_q  <= 1'b0;
`ifdef ISQRT_REM_EN
      rem_q    <= '0;
`endif
    end else begin
      op_q     <= op_d;
      rem_p_q  <= rem_p_d;
      root_p_q <= root_p_d;
      iter_q   <= iter_d;
      root_q   <= root_d;
      exact_q  <= exact_d;
`ifdef ISQRT_REM_EN
      rem_q    <= rem_d;
`endif
    end
  end

  // Handshake flags decode straight from the state register, so they can never overlap.
  always_comb begin
    busy  = (state_q == CALC);
    done  = (state_q == DONE);
    root  = root_q;
    exact = exact_q;
  end

`ifdef ISQRT_REM_EN
  assign rem = rem_q;
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq (WIDTH=8). A driver issues operations and
// pushes the reference result into a scoreboard queue; a monitor pops and
// compares whenever done rises. Works with or without ISQRT_REM_EN.
module tb_isqrt_seq;

  localparam int WIDTH = 8;
  localparam int RW    = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic [RW-1:0]    root;
  logic             exact;
`ifdef ISQRT_REM_EN
  logic [RW:0]      rem;
`endif

  isqrt_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .x    (x),
    .busy (busy),
    .done (done),
    .root (root),
    .exact(exact)
`ifdef ISQRT_REM_EN
    ,
    .rem  (rem)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int xv;
    int r;
    int ex;
    int rm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: largest r with r*r <= x, found by counting up.
  function automatic exp_t model(input int xv);
    exp_t e;
    int   r;
    r = 0;
    while ((r + 1) * (r + 1) <= xv) r++;
    e.xv = xv;
    e.r  = r;
    e.rm = xv - r * r;
    e.ex = (e.rm == 0) ? 1 : 0;
    return e;
  endfunction

  // Monitor: one comparison set per completed result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (busy && done) check("busy_done_overlap", 1, 0);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("root", int'(root), e.r);
          check("exact", int'(exact), e.ex);
`ifdef ISQRT_REM_EN
          check("rem", int'(rem), e.rm);
`endif
          $display("x=%0d root=%0d exact=%0d (model root=%0d exact=%0d rem=%0d)",
                   e.xv, root, exact, e.r, e.ex, e.rm);
        end
      end
      done_prev = done;
    end
  end

  // Issue one operation from IDLE/DONE; optionally pulse a stray start
  // (with a different x) 'ignore_at' cycles into CALC.
  task automatic run_op(input int xv, input int ignore_at);
    int cyc;
    int nbusy;
    int prev_root;
    prev_root = int'(root);
    start = 1'b1;
    x     = WIDTH'(xv);
    sb.push_back(model(xv));
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = WIDTH'($urandom);
    check("done_cleared_on_accept", int'(done), 0);
    cyc   = 0;
    nbusy = 0;
    while (!done && cyc < 20) begin
      if (busy) nbusy++;
      check("root_held_while_busy", int'(root), prev_root);
      if (cyc == ignore_at) begin
        start = 1'b1;
        x     = WIDTH'(9);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    check("latency", cyc, RW);
    check("busy_cycles", nbusy, RW);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_root", int'(root), 0);
    check("reset_exact", int'(exact), 0);
`ifdef ISQRT_REM_EN
    check("reset_rem", int'(rem), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Boundary and directed values
    run_op(0, -1);
    run_op(225, -1);
    run_op(255, -1);
    run_op(50, -1);

    // DONE holds without a new start
    repeat (3) @(posedge clk);
    #1;
    check("done_held", int'(done), 1);
    check("root_held_in_done", int'(root), 7);

    // Stray start while busy is ignored
    run_op(144, 2);

    // Reset mid-calculation clears everything asynchronously
    start = 1'b1;
    x     = WIDTH'(50);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_root", int'(root), 0);
    check("midreset_exact", int'(exact), 0);
`ifdef ISQRT_REM_EN
    check("midreset_rem", int'(rem), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(81, -1);

    // Exhaustive sweep, back-to-back from DONE
    for (int v = 0; v < (1 << WIDTH); v++) run_op(v, -1);

    // Random operands
    for (int i = 0; i < 40; i++) run_op(int'($urandom_range(0, (1 << WIDTH) - 1)), -1);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
